// File: rtl/note_sequencer_if.sv
// Note-program ROM bus between the sequencer (master) and the
// synchronous program ROM (slave). rom_data is valid on the cycle
// after rom_rd is high.
interface note_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [7:0]        rom_data;

  modport master (
    output rom_addr,
    output rom_rd,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_rd,
    output rom_data
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a note program in an external synchronous
// ROM and drives pitch/gate to the tone generator.
// Note word: [7:3] pitch (0 rest, 31 end marker), [2:0] dur -> (dur+1) beats.
// Optional build macro SEQ_LOOP_EN: an end marker at a non-zero address
// restarts the program from address 0 instead of stopping; an end marker at
// address 0 (empty program) still stops so playback cannot livelock.
//
// state  | meaning
// IDLE   | stopped, waiting for start
// FETCH  | rom_rd strobe issued for rom_addr
// DECODE | rom_data valid, decide note / rest / end marker
// PLAY   | counting down the note length, gate dropped for the final gap
// DONE   | end marker reached, silent, start restarts from address 0
module note_sequencer #(
  parameter int ADDR_W         = 6,
  parameter int TICKS_PER_BEAT = 3000,
  parameter int GAP_TICKS      = 300
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  note_sequencer_if.master rom_if,
  output logic [4:0]       pitch_o,
  output logic             gate_o,
  output logic             note_strobe_o,
  output logic             busy_o
);

  // Wide enough to hold 8 beats minus one without overflowing at dur=7.
  localparam int CNT_W = (8 * TICKS_PER_BEAT) > 1 ? $clog2(8 * TICKS_PER_BEAT) : 1;
  localparam logic [CNT_W-1:0] TPB_C = CNT_W'(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_TICKS);
  localparam logic [4:0] P_REST = 5'd0;
  localparam logic [4:0] P_END  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic [4:0]        pitch_q;
  logic              gate_q;
  logic              strobe_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  len_d;
  logic [4:0]        rom_pitch;
  logic [3:0]        beats;

  assign rom_pitch = rom_if.rom_data[7:3];
  assign beats     = {1'b0, rom_if.rom_data[2:0]} + 4'd1;

  // Counter load value L-1; arithmetic is modulo 2^CNT_W so the exact
  // power-of-two case (8*TICKS_PER_BEAT == 2^CNT_W) still lands on L-1.
  always_comb begin
    len_d = CNT_W'(beats) * TPB_C - CNT_W'(1);
  end

  // Sequencer FSM with all outputs registered so pitch/gate are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      pitch_q  <= P_REST;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (stop_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      pitch_q  <= P_REST;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rd_q     <= 1'b0;
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            addr_q  <= '0;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (rom_pitch == P_END) begin
`ifdef SEQ_LOOP_EN
            if (addr_q != '0) begin
              state_q <= S_FETCH;
              addr_q  <= '0;
              rd_q    <= 1'b1;
            end else begin
              state_q <= S_DONE;
              pitch_q <= P_REST;
              gate_q  <= 1'b0;
              busy_q  <= 1'b0;
            end
`else
            state_q <= S_DONE;
            pitch_q <= P_REST;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
`endif
          end else begin
            state_q  <= S_PLAY;
            pitch_q  <= rom_pitch;
            // L - GAP_TICKS is at least 1, so a tone always opens with gate high.
            gate_q   <= (rom_pitch != P_REST);
            cnt_q    <= len_d;
            strobe_q <= 1'b1;
          end
        end
        S_PLAY: begin
          if (cnt_q == '0) begin
            state_q <= S_FETCH;
            addr_q  <= addr_q + ADDR_W'(1);
            rd_q    <= 1'b1;
            gate_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            // Next cycle has count cnt_q-1; gate stays high while that is >= GAP.
            gate_q <= (pitch_q != P_REST) && (cnt_q > GAP_C);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_if.rom_addr = addr_q;
  assign rom_if.rom_rd   = rd_q;
  assign pitch_o         = pitch_q;
  assign gate_o          = gate_q;
  assign note_strobe_o   = strobe_q;
  assign busy_o          = busy_q;

endmodule
